// File: rtl/control_unit.sv
// control_unit: Moore sequencer for the 8-bit data path.
// Walks fetch/decode/execute one instruction at a time, drives every data path
// load/select strobe and the memory write enable. Outputs depend only on the
// current state and are held at zero while Reset is low.
module control_unit (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] IR,
  input  logic [3:0] CCR_Result,
  output logic       IR_Load,
  output logic       MAR_Load,
  output logic       PC_Load,
  output logic       PC_Inc,
  output logic       A_Load,
  output logic       B_Load,
  output logic [2:0] ALU_Sel,
  output logic       CCR_Load,
  output logic [1:0] Bus1_Sel,
  output logic [1:0] Bus2_Sel,
  output logic       write
);

  // Opcodes
  localparam logic [7:0] OP_LDA_IMM = 8'h86;
  localparam logic [7:0] OP_LDA_DIR = 8'h87;
  localparam logic [7:0] OP_LDB_IMM = 8'h88;
  localparam logic [7:0] OP_LDB_DIR = 8'h89;
  localparam logic [7:0] OP_STA_DIR = 8'h96;
  localparam logic [7:0] OP_STB_DIR = 8'h97;
  localparam logic [7:0] OP_ADD     = 8'h42;
  localparam logic [7:0] OP_SUB     = 8'h43;
  localparam logic [7:0] OP_AND     = 8'h44;
  localparam logic [7:0] OP_OR      = 8'h45;
  localparam logic [7:0] OP_INCA    = 8'h46;
  localparam logic [7:0] OP_BRA     = 8'h20;
  localparam logic [7:0] OP_BEQ     = 8'h23;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_INCA = 3'b100;

  // Bus source selects
  localparam logic [1:0] B1_PC  = 2'b00;
  localparam logic [1:0] B1_A   = 2'b01;
  localparam logic [1:0] B1_B   = 2'b10;
  localparam logic [1:0] B2_ALU = 2'b00;
  localparam logic [1:0] B2_B1  = 2'b01;
  localparam logic [1:0] B2_MEM = 2'b10;

  typedef enum logic [5:0] {
    S_FETCH_0   = 6'd0,
    S_FETCH_1   = 6'd1,
    S_FETCH_2   = 6'd2,
    S_DECODE_3  = 6'd3,
    S_LDA_IMM_4 = 6'd4,
    S_LDA_IMM_5 = 6'd5,
    S_LDA_IMM_6 = 6'd6,
    S_LDB_IMM_4 = 6'd7,
    S_LDB_IMM_5 = 6'd8,
    S_LDB_IMM_6 = 6'd9,
    S_LDA_DIR_4 = 6'd10,
    S_LDA_DIR_5 = 6'd11,
    S_LDA_DIR_6 = 6'd12,
    S_LDA_DIR_7 = 6'd13,
    S_LDA_DIR_8 = 6'd14,
    S_LDB_DIR_4 = 6'd15,
    S_LDB_DIR_5 = 6'd16,
    S_LDB_DIR_6 = 6'd17,
    S_LDB_DIR_7 = 6'd18,
    S_LDB_DIR_8 = 6'd19,
    S_STA_DIR_4 = 6'd20,
    S_STA_DIR_5 = 6'd21,
    S_STA_DIR_6 = 6'd22,
    S_STA_DIR_7 = 6'd23,
    S_STB_DIR_4 = 6'd24,
    S_STB_DIR_5 = 6'd25,
    S_STB_DIR_6 = 6'd26,
    S_STB_DIR_7 = 6'd27,
    S_ADD_4     = 6'd28,
    S_SUB_4     = 6'd29,
    S_AND_4     = 6'd30,
    S_OR_4      = 6'd31,
    S_INCA_4    = 6'd32,
    S_BRA_4     = 6'd33,
    S_BRA_5     = 6'd34,
    S_BRA_6     = 6'd35,
    S_BEQ_SKIP_4 = 6'd36
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Only the Z flag steers control flow; the remaining flags are not needed here.
  logic w_unused_flags;
  assign w_unused_flags = ^{CCR_Result[3], CCR_Result[1:0]};

  // State register: reset parks the sequencer at the start of fetch.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_FETCH_0;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: linear chains per instruction, decode dispatches on IR.
  always_comb begin
    w_next_state = S_FETCH_0;
    case (r_state)
      S_FETCH_0:   w_next_state = S_FETCH_1;
      S_FETCH_1:   w_next_state = S_FETCH_2;
      S_FETCH_2:   w_next_state = S_DECODE_3;
      S_DECODE_3: begin
        case (IR)
          OP_LDA_IMM: w_next_state = S_LDA_IMM_4;
          OP_LDB_IMM: w_next_state = S_LDB_IMM_4;
          OP_LDA_DIR: w_next_state = S_LDA_DIR_4;
          OP_LDB_DIR: w_next_state = S_LDB_DIR_4;
          OP_STA_DIR: w_next_state = S_STA_DIR_4;
          OP_STB_DIR: w_next_state = S_STB_DIR_4;
          OP_ADD:     w_next_state = S_ADD_4;
          OP_SUB:     w_next_state = S_SUB_4;
          OP_AND:     w_next_state = S_AND_4;
          OP_OR:      w_next_state = S_OR_4;
          OP_INCA:    w_next_state = S_INCA_4;
          OP_BRA:     w_next_state = S_BRA_4;
          OP_BEQ: begin
            // Taken branch reuses the BRA path; not taken just steps over the operand.
            if (CCR_Result[2]) begin
              w_next_state = S_BRA_4;
            end else begin
              w_next_state = S_BEQ_SKIP_4;
            end
          end
          default:    w_next_state = S_FETCH_0;  // illegal opcode behaves as NOP
        endcase
      end
      S_LDA_IMM_4: w_next_state = S_LDA_IMM_5;
      S_LDA_IMM_5: w_next_state = S_LDA_IMM_6;
      S_LDB_IMM_4: w_next_state = S_LDB_IMM_5;
      S_LDB_IMM_5: w_next_state = S_LDB_IMM_6;
      S_LDA_DIR_4: w_next_state = S_LDA_DIR_5;
      S_LDA_DIR_5: w_next_state = S_LDA_DIR_6;
      S_LDA_DIR_6: w_next_state = S_LDA_DIR_7;
      S_LDA_DIR_7: w_next_state = S_LDA_DIR_8;
      S_LDB_DIR_4: w_next_state = S_LDB_DIR_5;
      S_LDB_DIR_5: w_next_state = S_LDB_DIR_6;
      S_LDB_DIR_6: w_next_state = S_LDB_DIR_7;
      S_LDB_DIR_7: w_next_state = S_LDB_DIR_8;
      S_STA_DIR_4: w_next_state = S_STA_DIR_5;
      S_STA_DIR_5: w_next_state = S_STA_DIR_6;
      S_STA_DIR_6: w_next_state = S_STA_DIR_7;
      S_STB_DIR_4: w_next_state = S_STB_DIR_5;
      S_STB_DIR_5: w_next_state = S_STB_DIR_6;
      S_STB_DIR_6: w_next_state = S_STB_DIR_7;
      S_BRA_4:     w_next_state = S_BRA_5;
      S_BRA_5:     w_next_state = S_BRA_6;
      // Last execute states and any unreachable encoding return to fetch.
      default:     w_next_state = S_FETCH_0;
    endcase
  end

  // Output decode: strobes from state only, all forced low while Reset is asserted.
  always_comb begin
    IR_Load  = 1'b0;
    MAR_Load = 1'b0;
    PC_Load  = 1'b0;
    PC_Inc   = 1'b0;
    A_Load   = 1'b0;
    B_Load   = 1'b0;
    ALU_Sel  = ALU_ADD;
    CCR_Load = 1'b0;
    Bus1_Sel = B1_PC;
    Bus2_Sel = B2_ALU;
    write    = 1'b0;
    if (Reset) begin
      case (r_state)
        // MAR <- PC
        S_FETCH_0, S_LDA_IMM_4, S_LDB_IMM_4, S_LDA_DIR_4, S_LDB_DIR_4,
        S_STA_DIR_4, S_STB_DIR_4, S_BRA_4: begin
          MAR_Load = 1'b1;
          Bus1_Sel = B1_PC;
          Bus2_Sel = B2_B1;
        end
        // PC <- PC + 1
        S_FETCH_1, S_LDA_IMM_5, S_LDB_IMM_5, S_LDA_DIR_5, S_LDB_DIR_5,
        S_STA_DIR_5, S_STB_DIR_5, S_BEQ_SKIP_4: begin
          PC_Inc = 1'b1;
        end
        S_FETCH_2: begin
          IR_Load  = 1'b1;
          Bus2_Sel = B2_MEM;
        end
        // MAR <- mem (direct address operand)
        S_LDA_DIR_6, S_LDB_DIR_6, S_STA_DIR_6, S_STB_DIR_6: begin
          MAR_Load = 1'b1;
          Bus2_Sel = B2_MEM;
        end
        S_LDA_IMM_6, S_LDA_DIR_8: begin
          A_Load   = 1'b1;
          Bus2_Sel = B2_MEM;
        end
        S_LDB_IMM_6, S_LDB_DIR_8: begin
          B_Load   = 1'b1;
          Bus2_Sel = B2_MEM;
        end
        S_STA_DIR_7: begin
          write    = 1'b1;
          Bus1_Sel = B1_A;
        end
        S_STB_DIR_7: begin
          write    = 1'b1;
          Bus1_Sel = B1_B;
        end
        S_ADD_4, S_SUB_4, S_AND_4, S_OR_4, S_INCA_4: begin
          A_Load   = 1'b1;
          CCR_Load = 1'b1;
          Bus1_Sel = B1_A;
          Bus2_Sel = B2_ALU;
          case (r_state)
            S_SUB_4:  ALU_Sel = ALU_SUB;
            S_AND_4:  ALU_Sel = ALU_AND;
            S_OR_4:   ALU_Sel = ALU_OR;
            S_INCA_4: ALU_Sel = ALU_INCA;
            default:  ALU_Sel = ALU_ADD;
          endcase
        end
        S_BRA_6: begin
          PC_Load  = 1'b1;
          Bus2_Sel = B2_MEM;
        end
        // Decode and memory-latency wait states drive nothing.
        S_DECODE_3, S_LDA_DIR_7, S_LDB_DIR_7, S_BRA_5: begin
          write = 1'b0;
        end
        default: begin
          write = 1'b0;
        end
      endcase
    end else begin
      write = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: an instruction-level model expands each
// opcode into its expected per-cycle strobe vectors; a monitor compares every cycle.
module tb_control_unit;

  logic       Clk;
  logic       Reset;
  logic [7:0] IR;
  logic [3:0] CCR_Result;
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write;
  logic [2:0] ALU_Sel;
  logic [1:0] Bus1_Sel, Bus2_Sel;

  control_unit dut (
    .Clk(Clk), .Reset(Reset), .IR(IR), .CCR_Result(CCR_Result),
    .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
    .A_Load(A_Load), .B_Load(B_Load), .ALU_Sel(ALU_Sel), .CCR_Load(CCR_Load),
    .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel), .write(write)
  );

  typedef struct {
    logic [14:0] v;
    logic [7:0]  op;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Observed strobe vector
  logic [14:0] act;
  assign act = {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, ALU_Sel,
                CCR_Load, Bus1_Sel, Bus2_Sel, write};

  // Vector builder: field order matches the act concatenation above.
  function automatic logic [14:0] mv(input logic ir, input logic mar, input logic pcl,
                                     input logic pci, input logic a, input logic b,
                                     input logic [2:0] alu, input logic ccr,
                                     input logic [1:0] b1, input logic [1:0] b2,
                                     input logic wr);
    return {ir, mar, pcl, pci, a, b, alu, ccr, b1, b2, wr};
  endfunction

  // Named micro-operations
  function automatic logic [14:0] u_mar_pc();  return mv(0,1,0,0,0,0,3'd0,0,2'b00,2'b01,0); endfunction
  function automatic logic [14:0] u_inc();     return mv(0,0,0,1,0,0,3'd0,0,2'b00,2'b00,0); endfunction
  function automatic logic [14:0] u_ir();      return mv(1,0,0,0,0,0,3'd0,0,2'b00,2'b10,0); endfunction
  function automatic logic [14:0] u_none();    return 15'd0; endfunction
  function automatic logic [14:0] u_mar_mem(); return mv(0,1,0,0,0,0,3'd0,0,2'b00,2'b10,0); endfunction
  function automatic logic [14:0] u_a_mem();   return mv(0,0,0,0,1,0,3'd0,0,2'b00,2'b10,0); endfunction
  function automatic logic [14:0] u_b_mem();   return mv(0,0,0,0,0,1,3'd0,0,2'b00,2'b10,0); endfunction
  function automatic logic [14:0] u_pc_mem();  return mv(0,0,1,0,0,0,3'd0,0,2'b00,2'b10,0); endfunction
  function automatic logic [14:0] u_wr(input logic [1:0] src); return mv(0,0,0,0,0,0,3'd0,0,src,2'b00,1); endfunction
  function automatic logic [14:0] u_alu(input logic [2:0] f); return mv(0,0,0,0,1,0,f,1,2'b01,2'b00,0); endfunction

  int cyc_n;
  logic [7:0] cur_op;

  task automatic push(input logic [14:0] v);
    exp_t e;
    cyc_n = cyc_n + 1;
    e.v = v; e.op = cur_op; e.cyc = cyc_n;
    sb.push_back(e);
  endtask

  // Reference model: instruction -> sequence of register transfers.
  task automatic model(input logic [7:0] op, input logic [3:0] ccr, output int n);
    cyc_n = 0;
    cur_op = op;
    push(u_mar_pc()); push(u_inc()); push(u_ir()); push(u_none());
    case (op)
      8'h86: begin push(u_mar_pc()); push(u_inc()); push(u_a_mem()); end
      8'h88: begin push(u_mar_pc()); push(u_inc()); push(u_b_mem()); end
      8'h87: begin push(u_mar_pc()); push(u_inc()); push(u_mar_mem()); push(u_none()); push(u_a_mem()); end
      8'h89: begin push(u_mar_pc()); push(u_inc()); push(u_mar_mem()); push(u_none()); push(u_b_mem()); end
      8'h96: begin push(u_mar_pc()); push(u_inc()); push(u_mar_mem()); push(u_wr(2'b01)); end
      8'h97: begin push(u_mar_pc()); push(u_inc()); push(u_mar_mem()); push(u_wr(2'b10)); end
      8'h42: push(u_alu(3'b000));
      8'h43: push(u_alu(3'b001));
      8'h44: push(u_alu(3'b010));
      8'h45: push(u_alu(3'b011));
      8'h46: push(u_alu(3'b100));
      8'h20: begin push(u_mar_pc()); push(u_none()); push(u_pc_mem()); end
      8'h23: begin
        if (ccr[2] == 1'b1) begin push(u_mar_pc()); push(u_none()); push(u_pc_mem()); end
        else push(u_inc());
      end
      default: ;
    endcase
    n = cyc_n;
  endtask

  // Issue one instruction (called just after a rising edge) and let it run.
  task automatic run(input logic [7:0] op, input logic [3:0] ccr);
    int n;
    IR = op;
    CCR_Result = ccr;
    model(op, ccr, n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    checks = checks + 1;
    if (act !== 15'd0) begin
      errors = errors + 1;
      $display("FAIL %s act=%h exp=%h", name, act, 15'd0);
    end
  endtask

  // Monitor: every cycle out of reset, compare DUT strobes against the scoreboard.
  always @(negedge Clk) begin
    if (Reset === 1'b1) begin
      checks = checks + 1;
      if (sb.size() == 0) begin
        errors = errors + 1;
        $display("FAIL sb_underflow act=%h exp=none", act);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (act !== e.v) begin
          errors = errors + 1;
          $display("FAIL op%h_cyc%0d act=%h exp=%h", e.op, e.cyc, act, e.v);
        end
      end
    end
  end

  logic [7:0] legal [14] = '{8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97, 8'h42,
                             8'h43, 8'h44, 8'h45, 8'h46, 8'h20, 8'h23, 8'hFF};

  // Stimulus sequence
  initial begin
    int n9;
    logic [7:0] op;
    Reset = 1'b0;
    IR = 8'h00;
    CCR_Result = 4'h0;
    repeat (3) @(posedge Clk);
    #1;
    check_zero("reset_outputs");
    Reset = 1'b1;

    // Directed instructions, including both BEQ outcomes and an illegal opcode
    run(8'h86, 4'h0);
    run(8'h96, 4'h0);
    run(8'h43, 4'h0);
    run(8'h23, 4'b0100);
    run(8'h23, 4'b0000);
    run(8'hFF, 4'h0);
    for (int i = 0; i < 13; i++) run(legal[i], 4'(i));

    // Reset asserted during X6 of LDA_DIR
    IR = 8'h87;
    CCR_Result = 4'h0;
    model(8'h87, 4'h0, n9);
    repeat (6) @(posedge Clk);
    @(negedge Clk);
    #1;
    Reset = 1'b0;
    #1;
    check_zero("reset_mid_instr");
    checks = checks + 1;
    if (sb.size() != 2) begin
      errors = errors + 1;
      $display("FAIL abort_depth act=%0d exp=%0d", sb.size(), 2);
    end
    sb.delete();
    @(posedge Clk);
    #1;
    check_zero("reset_held");
    Reset = 1'b1;
    run(8'h86, 4'h0);

    // Randomized instruction stream
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 15) < 13) op = legal[$urandom_range(0, 13)];
      else op = 8'($urandom_range(0, 255));
      run(op, 4'($urandom_range(0, 15)));
    end

    Reset = 1'b0;
    #1;
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL sb_leftover act=%0d exp=%0d", sb.size(), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Time bound
  initial begin
    #500000;
    errors = errors + 1;
    $display("FAIL watchdog act=timeout exp=done");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
